// File: rtl/fixp_pkg.sv
// rtl/fixp_pkg.sv - shared state encoding, default widths and range helpers for the fixed-point divider
package fixp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } fixp_state_t;

    localparam int W_DEF = 16;
    localparam int F_DEF = 8;

    // Largest positive W-bit two's-complement value, zero-extended to 64 bits.
    function automatic logic [63:0] max_val(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative W-bit value; also the largest negative magnitude.
    function automatic logic [63:0] min_val(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fixp_sat.sv
// rtl/fixp_sat.sv - applies the result sign to a quotient magnitude and saturates it to W bits
module fixp_sat
    import fixp_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int MW = W + 1
) (
    input  logic [MW-1:0] mag_i,
    input  logic          neg_i,
    output logic [W-1:0]  q_o,
    output logic          ovf_o
);

    localparam logic [MW-1:0] POS_LIM = MW'(max_val(W));
    localparam logic [MW-1:0] NEG_LIM = MW'(min_val(W));
    localparam logic [W-1:0]  Q_MAX   = W'(max_val(W));
    localparam logic [W-1:0]  Q_MIN   = W'(min_val(W));

    always_comb begin
        q_o   = mag_i[W-1:0];
        ovf_o = 1'b0;
        if (neg_i) begin
            if (mag_i > NEG_LIM) begin
                q_o   = Q_MIN;
                ovf_o = 1'b1;
            end else begin
                q_o = -mag_i[W-1:0];
            end
        end else if (mag_i > POS_LIM) begin
            q_o   = Q_MAX;
            ovf_o = 1'b1;
        end
    end

endmodule

// File: rtl/fixp_divider.sv
// rtl/fixp_divider.sv - signed Q(W-F).F restoring divider, one quotient bit per cycle; FIXP_DIV_ROUND_EN adds round-half-away
module fixp_divider
    import fixp_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int F = F_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q,
    output logic         ovf,
    output logic         dbz
);

`ifdef FIXP_DIV_ROUND_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int N  = W + F + RB;
    localparam int CW = $clog2(N + 1);
    localparam int MW = W + F + 1;
    localparam logic [W-1:0] Q_MAX = W'(max_val(W));
    localparam logic [W-1:0] Q_MIN = W'(min_val(W));

    fixp_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dq_q, dq_d;
    logic [W:0]    rem_q, rem_d;
    logic [W-1:0]  bmag_q, bmag_d;
    logic          neg_q, neg_d;
    logic [W-1:0]  q_q, q_d;
    logic          ovf_q, ovf_d;
    logic          dbz_q, dbz_d;
    logic          out_valid_q, out_valid_d;

    logic [W-1:0]  a_mag, b_mag;
    logic [W:0]    rem_sh, rem_diff;
    logic          rem_ge;
    logic [MW-1:0] mag;
    logic [W-1:0]  sat_q;
    logic          sat_ovf;

    // Negating the most negative value yields 2^(W-1) as an unsigned pattern, which is the wanted magnitude.
    assign a_mag = a[W-1] ? W'(-a) : a;
    assign b_mag = b[W-1] ? W'(-b) : b;

    // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom.
    assign rem_sh   = {rem_q[W-1:0], dq_q[N-1]};
    assign rem_diff = rem_sh - {1'b0, bmag_q};
    assign rem_ge   = rem_sh >= {1'b0, bmag_q};

`ifdef FIXP_DIV_ROUND_EN
    assign mag = (dq_q >> 1) + MW'(dq_q[0]);
`else
    assign mag = MW'(dq_q);
`endif

    fixp_sat #(.W(W), .MW(MW)) u_sat (
        .mag_i (mag),
        .neg_i (neg_q),
        .q_o   (sat_q),
        .ovf_o (sat_ovf)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dq_d        = dq_q;
        rem_d       = rem_q;
        bmag_d      = bmag_q;
        neg_d       = neg_q;
        q_d         = q_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    bmag_d = b_mag;
                    neg_d  = a[W-1] ^ b[W-1];
                    dq_d   = N'(a_mag) << (F + RB);
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (b == '0) begin
                        q_d     = a[W-1] ? Q_MIN : Q_MAX;
                        ovf_d   = 1'b0;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = rem_ge ? rem_diff : rem_sh;
                dq_d  = {dq_q[N-2:0], rem_ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                q_d     = sat_q;
                ovf_d   = sat_ovf;
                dbz_d   = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // out_valid lags DONE entry by one edge; results are already stable when it rises.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dq_q        <= '0;
            rem_q       <= '0;
            bmag_q      <= '0;
            neg_q       <= 1'b0;
            q_q         <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dq_q        <= dq_d;
            rem_q       <= rem_d;
            bmag_q      <= bmag_d;
            neg_q       <= neg_d;
            q_q         <= q_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_fixp_divider.sv
// tb/tb_fixp_divider.sv - randomized and directed bench for fixp_divider against an arithmetic quotient model
module tb_fixp_divider;

    localparam int W = 16;
    localparam int F = 8;
`ifdef FIXP_DIV_ROUND_EN
    localparam int N = W + F + 1;
`else
    localparam int N = W + F;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  q;
    logic          ovf;
    logic          dbz;

    int n_cmp = 0;
    int n_bad = 0;

    fixp_divider #(.W(W), .F(F)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact rational quotient |a|*2^F/|b|, truncated or rounded half away, then signed and range-limited.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         output logic [W-1:0] eq, output logic eovf, output logic edbz);
        longint sa, sb, ma, mb, mag;
        bit neg;
        sa = longint'($signed(ta));
        sb = longint'($signed(tb_v));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        neg = (sa < 0) != (sb < 0);
        edbz = 1'b0;
        eovf = 1'b0;
        if (sb == 0) begin
            eq   = (sa < 0) ? 16'h8000 : 16'h7FFF;
            edbz = 1'b1;
        end else begin
`ifdef FIXP_DIV_ROUND_EN
            mag = ((ma * (64'sd1 << (F + 1))) + mb) / (2 * mb);
`else
            mag = (ma * (64'sd1 << F)) / mb;
`endif
            if (!neg && mag > 32767) begin
                eq = 16'h7FFF; eovf = 1'b1;
            end else if (neg && mag > 32768) begin
                eq = 16'h8000; eovf = 1'b1;
            end else begin
                eq = neg ? W'(-mag) : W'(mag);
            end
        end
    endtask

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        int g;
        @(negedge clk);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic finish_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        logic [W-1:0] eq;
        logic eovf, edbz;
        int lat;
        model(ta, tb_v, eq, eovf, edbz);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), edbz ? 32'd1 : 32'(N + 2));
        check({tag, "_q"}, {16'd0, q}, {16'd0, eq});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
        check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, edbz});
    endtask

    task automatic drain(input string tag);
        logic [W-1:0] held;
        held = q;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_retain_q"}, {16'd0, q}, {16'd0, held});
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        start_op(ta, tb_v);
        finish_op(tag, ta, tb_v);
        drain(tag);
    endtask

    initial begin
        logic [W-1:0] ra, rb, held;
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_q", {16'd0, q}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_dbz", {31'd0, dbz}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        full_op("d_3_2", 16'h0300, 16'h0200);
        full_op("d_2_3", 16'h0200, 16'h0300);
        full_op("d_m3_2", 16'hFD00, 16'h0200);
        full_op("d_min_m1", 16'h8000, 16'hFF00);
        full_op("d_big", 16'h7F00, 16'h0010);
        full_op("d_dbz_neg", 16'hFF00, 16'h0000);
        full_op("d_dbz_pos", 16'h0100, 16'h0000);
        full_op("d_min_1", 16'h8000, 16'h0100);
        full_op("d_zero", 16'h0000, 16'hFE00);

        // Held result with a pending request: no second accept until the handshake.
        start_op(16'h0300, 16'h0200);
        finish_op("hold", 16'h0300, 16'h0200);
        held = q;
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h0500;
        b = 16'h0100;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_q", {16'd0, q}, {16'd0, held});
            check("hold_ready", {31'd0, in_ready}, 32'd0);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("hold_next_accept", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        finish_op("hold_next", 16'h0500, 16'h0100);
        drain("hold_next");

        // Reset mid-division.
        start_op(16'h0700, 16'h0300);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_q", {16'd0, q}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        full_op("after_rst", 16'h0300, 16'h0200);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 8));
                2: ra = 16'h8000;
                3: rb = 16'hFFFF;
                default: ;
            endcase
            full_op("rnd", ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/fixp_divider.md
FIXP_DIVIDER -- requirements
Module: fixp_divider

Interface
REQ-001 Parameter W, default 16, SHALL set the total two's-complement operand/result width.
REQ-002 Parameter F, default 8, SHALL set the fraction bits (Q(W-F).F); legal range 0 <= F < W, W >= 4.
REQ-003 clk  in  1  rising-edge clock; the block SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  operand pair present.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 a  in  W  signed dividend.
REQ-008 b  in  W  signed divisor.
REQ-009 out_valid  out  1  result present.
REQ-010 out_ready  in  1  consumer takes result.
REQ-011 q  out  W  signed quotient a/b, Q(W-F).F.
REQ-012 ovf  out  1  result saturated due to range overflow.
REQ-013 dbz  out  1  divide-by-zero occurred.

Function
REQ-014 FSM SHALL have states IDLE, CALC, FIX, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept SHALL occur on a rising edge with in_valid&in_ready; it SHALL capture |a| (W bits, covers -2^(W-1)), |b|, sign=a[W-1]^b[W-1], and dividend |a|<<F (W+F bits); then IDLE->CALC.
REQ-016 CALC SHALL run a radix-2 restoring division, one quotient bit per cycle, N=W+F iterations, with a W+1-bit partial remainder; then CALC->FIX.
REQ-017 FIX SHALL apply the sign and saturate: positive magnitude > 2^(W-1)-1 -> q=max, ovf=1; negative magnitude > 2^(W-1) -> q=min, ovf=1; otherwise q is the exact two's complement result, truncated toward zero; then FIX->DONE.
REQ-018 Latency SHALL be exactly N+2 rising edges from the accept edge to the edge on which out_valid rises.
REQ-019 If b==0 at accept, the block SHALL go IDLE->DONE directly with dbz=1, ovf=0, q=max if a>=0 or min if a<0; out_valid SHALL rise on the edge after the accept edge.
REQ-020 In DONE, out_valid=1 and q/ovf/dbz SHALL hold stable until out_valid&out_ready; on that edge DONE->IDLE and out_valid=0.
REQ-021 The block SHALL accept no new operands in DONE, even when out_ready is 1 (no bypass); a/b changes after accept SHALL be ignored.
REQ-022 q/ovf/dbz SHALL retain the last result after handshake until the next FIX or b==0 accept overwrites them.

Reset
REQ-023 rst_n low SHALL force state IDLE, out_valid=0, q=0, ovf=0, dbz=0, iteration counter=0, and in_ready=1, at any time including mid-CALC, with no output of partial results.
REQ-024 After rst_n deasserts, operands SHALL be accepted on the first edge with in_valid=1.

Configuration
REQ-025 Macro FIXP_DIV_ROUND_EN, when defined, SHALL add one extra iteration (N=W+F+1, latency +1) and round the magnitude half away from zero before saturation.
REQ-026 When FIXP_DIV_ROUND_EN is undefined, results SHALL truncate toward zero and N=W+F.

Structure
REQ-027 Shared package fixp_pkg SHALL hold the state enum typedef and the default W/F constants, and SHALL provide max/min value functions for the width.
REQ-028 Sign-apply/saturation SHALL be a sub-module fixp_sat (combinational, parameter W, magnitude in, sign in, q/ovf out); the iteration datapath stays in fixp_divider.

Verification (W=16, F=8)
REQ-029 a=0x0300, b=0x0200 -> q=0x0180, ovf=0, dbz=0, out_valid 26 edges after accept.
REQ-030 a=0x0200, b=0x0300 -> q=0x00AA without FIXP_DIV_ROUND_EN; q=0x00AB with it, at 27 edges.
REQ-031 a=0xFD00, b=0x0200 -> q=0xFE80; a=0x8000, b=0xFF00 -> q=0x7FFF, ovf=1; a=0x7F00, b=0x0010 -> q=0x7FFF, ovf=1.
REQ-032 a=0xFF00, b=0x0000 -> q=0x8000, dbz=1, out_valid on the next edge; a=0x0100, b=0 -> q=0x7FFF.
REQ-033 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> q stable, in_ready=0, no second accept; out_ready=1 -> IDLE, next accept occurs on the following edge.
REQ-034 Pulse rst_n low at iteration 5 of CALC -> out_valid=0, q=0, in_ready=1 immediately; a fresh a=0x0300, b=0x0200 then yields q=0x0180.
